// File: rtl/lpm_mem_sched.sv
// lpm_mem_sched: arbitrates the shared LPM memory port between new and recirculating lookups (optional LPM_SCHED_STATS_EN adds stat_done/stat_recirc counters)
module lpm_mem_sched #(
    parameter int DATA_WIDTH      = 704,
    parameter int ITER_COUNT      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic                                 in__ENA,
    input  logic [DATA_WIDTH-1:0]                in_v,
    output logic                                 in__RDY,
    output logic                                 mem_req__ENA,
    output logic [DATA_WIDTH-1:0]                mem_req_v,
    input  logic                                 mem_req__RDY,
    input  logic [DATA_WIDTH-1:0]                mem_resValue,
    input  logic                                 mem_resValue__RDY,
    output logic                                 mem_resAccept__ENA,
    input  logic                                 mem_resAccept__RDY,
    output logic                                 out__ENA,
    output logic [DATA_WIDTH-1:0]                out_v,
    input  logic                                 out__RDY,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
`ifdef LPM_SCHED_STATS_EN
    output logic                                 protocol_err,
    output logic [31:0]                          stat_done,
    output logic [31:0]                          stat_recirc
`else
    output logic                                 protocol_err
`endif
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int OW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [7:0]    tags [MAX_OUTSTANDING];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [SW-1:0] starve;
    logic [7:0]    head;
    logic [8:0]    head_inc;
    logic          not_empty, resp_ok, last, recirc_want, force_new, room;
    logic          new_ok, new_fire, exit_fire, recirc_fire, contend, push, pop;
    logic [7:0]    push_val;

    // The FIFO holds exactly one tag per in-flight lookup, so its occupancy is outstanding.
    assign head        = tags[rd_ptr];
    assign head_inc    = {1'b0, head} + 9'd1;
    assign not_empty   = outstanding != '0;
    assign resp_ok     = mem_resValue__RDY & mem_resAccept__RDY & not_empty;
    assign last        = head_inc == 9'(ITER_COUNT);
    assign recirc_want = resp_ok & ~last;
    assign force_new   = starve == SW'(STARVE_LIMIT);
    assign room        = outstanding < OW'(MAX_OUTSTANDING);
    assign new_ok      = nRST & mem_req__RDY & room & (~recirc_want | force_new);
    assign new_fire    = in__ENA & new_ok;
    assign exit_fire   = resp_ok & last & out__RDY;
    assign recirc_fire = recirc_want & mem_req__RDY & ~force_new;
    assign contend     = in__ENA & mem_req__RDY & room & recirc_want & ~force_new;
    assign push        = new_fire | recirc_fire;
    assign pop         = exit_fire | recirc_fire;
    assign push_val    = new_fire ? 8'd0 : head_inc[7:0];

    assign in__RDY            = new_ok;
    assign mem_req__ENA       = push;
    assign mem_req_v          = new_fire ? in_v : mem_resValue;
    assign mem_resAccept__ENA = pop;
    assign out__ENA           = exit_fire;
    assign out_v              = mem_resValue;

    // Tag storage needs no reset: entries are only read while occupied.
    always_ff @(posedge CLK) begin
        if (push) tags[wr_ptr] <= push_val;
    end

    // Pointers, occupancy, starvation tracking and sticky error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            outstanding  <= '0;
            starve       <= '0;
            protocol_err <= 1'b0;
        end else begin
            rd_ptr       <= rd_ptr + AW'(pop);
            wr_ptr       <= wr_ptr + AW'(push);
            outstanding  <= outstanding + OW'(new_fire) - OW'(exit_fire);
            starve       <= (!new_fire && contend) ? starve + SW'(1) : '0;
            protocol_err <= protocol_err | (mem_resValue__RDY & ~not_empty);
        end
    end

`ifdef LPM_SCHED_STATS_EN
    // Completion and recirculation counters, wrapping naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_done   <= '0;
            stat_recirc <= '0;
        end else begin
            stat_done   <= stat_done + 32'(exit_fire);
            stat_recirc <= stat_recirc + 32'(recirc_fire);
        end
    end
`endif
endmodule

// File: tb/tb_lpm_mem_sched.sv
// tb_lpm_mem_sched: directed checks of lpm_mem_sched against a 1-cycle in-order memory model
module tb_lpm_mem_sched;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in__ENA = 1'b0;
    logic [DW-1:0] in_v = '0;
    logic          in__RDY;
    logic          mem_req__ENA;
    logic [DW-1:0] mem_req_v;
    logic          mem_req__RDY = 1'b1;
    logic [DW-1:0] mem_resValue;
    logic          mem_resValue__RDY;
    logic          mem_resAccept__ENA;
    logic          mem_resAccept__RDY = 1'b1;
    logic          out__ENA;
    logic [DW-1:0] out_v;
    logic          out__RDY = 1'b1;
    logic [2:0]    outstanding;
    logic          protocol_err;
`ifdef LPM_SCHED_STATS_EN
    logic [31:0]   stat_done, stat_recirc;
`endif

    lpm_mem_sched #(.DATA_WIDTH(DW), .ITER_COUNT(5), .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .CLK(CLK), .nRST(nRST), .in__ENA(in__ENA), .in_v(in_v), .in__RDY(in__RDY),
        .mem_req__ENA(mem_req__ENA), .mem_req_v(mem_req_v), .mem_req__RDY(mem_req__RDY),
        .mem_resValue(mem_resValue), .mem_resValue__RDY(mem_resValue__RDY),
        .mem_resAccept__ENA(mem_resAccept__ENA), .mem_resAccept__RDY(mem_resAccept__RDY),
        .out__ENA(out__ENA), .out_v(out_v), .out__RDY(out__RDY),
        .outstanding(outstanding),
`ifdef LPM_SCHED_STATS_EN
        .protocol_err(protocol_err), .stat_done(stat_done), .stat_recirc(stat_recirc)
`else
        .protocol_err(protocol_err)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: each request returns request+1 one cycle later, in order.
    logic [DW-1:0] mq [16];
    logic [3:0]    mh, mt;
    logic          mem_on = 1'b0;
    logic          fake_resp = 1'b0;
    assign mem_resValue      = mq[mh];
    assign mem_resValue__RDY = (mem_on && mh != mt) || fake_resp;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mh <= '0;
            mt <= '0;
        end else begin
            if (mem_resAccept__ENA) mh <= mh + 4'd1;
            if (mem_req__ENA) begin
                mq[mt] <= mem_req_v + DW'(1);
                mt <= mt + 4'd1;
            end
        end
    end

    // Handshake monitor.
    int n_rc = 0, n_out = 0, n_new = 0;
    logic [DW-1:0] last_out = '0;
    always @(posedge CLK) begin
        if (mem_req__ENA && mem_resAccept__ENA) n_rc <= n_rc + 1;
        if (mem_req__ENA && !mem_resAccept__ENA) n_new <= n_new + 1;
        if (out__ENA) begin
            n_out <= n_out + 1;
            last_out <= out_v;
        end
    end

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [DW-1:0] v);
        @(negedge CLK);
        in_v = v;
        in__ENA = 1'b1;
        @(negedge CLK);
        in__ENA = 1'b0;
    endtask

    int s_rc, s_out, s_new, bad;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        in__ENA = 1'b1;
        #1;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_in_rdy", 32'(in__RDY), 0);
        chk("rst_perr", 32'(protocol_err), 0);
        chk("rst_req_ena", 32'(mem_req__ENA), 0);
        in__ENA = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        mem_on = 1'b1;

        // Single lookup, 4 recirculations then exit with 100+5
        s_rc = n_rc; s_out = n_out;
        @(negedge CLK);
        in_v = 16'd100;
        in__ENA = 1'b1;
        #1 chk("t1_in_rdy", 32'(in__RDY), 1);
        @(negedge CLK);
        in__ENA = 1'b0;
        chk("t1_out1", 32'(outstanding), 1);
        repeat (10) @(negedge CLK);
        chk("t1_recirc", 32'(n_rc - s_rc), 4);
        chk("t1_exits", 32'(n_out - s_out), 1);
        chk("t1_word", 32'(last_out), 105);
        chk("t1_out0", 32'(outstanding), 0);

        // Credit limit: 6 offered with silent memory, 4 accepted
        mem_on = 1'b0;
        s_new = n_new; s_out = n_out;
        @(negedge CLK);
        in_v = 16'd200;
        in__ENA = 1'b1;
        repeat (6) @(negedge CLK);
        #1;
        chk("t2_new", 32'(n_new - s_new), 4);
        chk("t2_full", 32'(outstanding), 4);
        chk("t2_in_rdy", 32'(in__RDY), 0);
        chk("t2_no_req", 32'(mem_req__ENA), 0);
        in__ENA = 1'b0;
        mem_on = 1'b1;
        repeat (40) @(negedge CLK);
        chk("t2_drain", 32'(outstanding), 0);
        chk("t2_exits", 32'(n_out - s_out), 4);

        // Starvation: 3 lookups recirculating, new lookup forced on 9th contended cycle
        mem_on = 1'b0;
        issue(16'd10);
        issue(16'd20);
        issue(16'd30);
        @(negedge CLK);
        mem_on = 1'b1;
        in_v = 16'd777;
        in__ENA = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (in__RDY !== 1'b0 || mem_resAccept__ENA !== 1'b1) bad++;
            @(negedge CLK);
        end
        #1;
        chk("t3_contended", 32'(bad), 0);
        chk("t3_force_rdy", 32'(in__RDY), 1);
        chk("t3_force_word", 32'(mem_req_v), 777);
        chk("t3_recirc_stall", 32'(mem_resAccept__ENA), 0);
        @(negedge CLK);
        in__ENA = 1'b0;
        #1;
        chk("t3_out4", 32'(outstanding), 4);
        chk("t3_recirc_resume", 32'(mem_resAccept__ENA), 1);
        repeat (50) @(negedge CLK);
        chk("t3_drain", 32'(outstanding), 0);

        // Output backpressure on last pass, then exit together with a new issue
        out__RDY = 1'b0;
        issue(16'd50);
        repeat (8) @(negedge CLK);
        #1;
        chk("t4_held_acc", 32'(mem_resAccept__ENA), 0);
        chk("t4_held_out", 32'(out__ENA), 0);
        chk("t4_held_valid", 32'(mem_resValue__RDY), 1);
        chk("t4_held_outst", 32'(outstanding), 1);
        out__RDY = 1'b1;
        in_v = 16'd300;
        in__ENA = 1'b1;
        #1;
        chk("t4_exit", 32'(out__ENA), 1);
        chk("t4_exit_word", 32'(out_v), 55);
        chk("t4_new_rdy", 32'(in__RDY), 1);
        @(negedge CLK);
        in__ENA = 1'b0;
        chk("t4_same_outst", 32'(outstanding), 1);
        repeat (10) @(negedge CLK);
        chk("t4_word2", 32'(last_out), 305);
        chk("t4_drain", 32'(outstanding), 0);

        // Response with empty FIFO, then reset mid-traffic
        fake_resp = 1'b1;
        #1 chk("t5_no_accept", 32'(mem_resAccept__ENA), 0);
        @(negedge CLK);
        fake_resp = 1'b0;
        chk("t5_perr", 32'(protocol_err), 1);
        repeat (3) @(negedge CLK);
        chk("t5_perr_sticky", 32'(protocol_err), 1);
        issue(16'd400);
        @(negedge CLK);
        nRST = 1'b0;
        in__ENA = 1'b1;
        #1;
        chk("t5_rst_outst", 32'(outstanding), 0);
        chk("t5_rst_perr", 32'(protocol_err), 0);
        chk("t5_rst_req", 32'(mem_req__ENA), 0);
        chk("t5_rst_acc", 32'(mem_resAccept__ENA), 0);
        chk("t5_rst_out", 32'(out__ENA), 0);
        chk("t5_rst_in_rdy", 32'(in__RDY), 0);
        @(negedge CLK);
        in__ENA = 1'b0;
        nRST = 1'b1;

`ifdef LPM_SCHED_STATS_EN
        mem_on = 1'b0;
        issue(16'd1);
        issue(16'd2);
        issue(16'd3);
        mem_on = 1'b1;
        repeat (40) @(negedge CLK);
        chk("st_done", stat_done, 3);
        chk("st_recirc", stat_recirc, 12);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
